// File: rtl/exec_pkg.sv
// exec_pkg: shared encodings for the RV64I EX stage and its iterative M-extension unit.
// Used by execute_muldiv and muldiv_iter; the divider is built only when DIV_EN is defined.
package exec_pkg;

    typedef enum logic [3:0] {
        ALU_ADD     = 4'd0,
        ALU_SUB     = 4'd1,
        ALU_AND     = 4'd2,
        ALU_OR      = 4'd3,
        ALU_XOR     = 4'd4,
        ALU_SLT     = 4'd5,
        ALU_SLTU    = 4'd6,
        ALU_SLL     = 4'd7,
        ALU_SRL     = 4'd8,
        ALU_SRA     = 4'd9,
        ALU_SH1ADD  = 4'd10,
        ALU_SH2ADD  = 4'd11,
        ALU_SH3ADD  = 4'd12,
        ALU_ADD_UW  = 4'd13,
        ALU_SLLI_UW = 4'd14
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } muldiv_op_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    typedef enum logic [1:0] {
        FWD_RD     = 2'b00,
        FWD_WB     = 2'b01,
        FWD_MEM    = 2'b10,
        FWD_RD_ALT = 2'b11
    } fwd_sel_e;

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one-bit-per-cycle RV M-extension unit (shift-add multiply, restoring divide).
// Divider datapath exists only when DIV_EN is defined; otherwise divide ops never start.
module muldiv_iter
    import exec_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic            flush_i,
    input  logic            muldiv_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;

    logic              start, op_ok, a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step, prod;

`ifdef DIV_EN
    logic              negr_q, negr_d, bzero_q, bzero_d;
    logic [XLEN:0]     rem_sh;
    logic              div_ge;
    logic [2*XLEN-1:0] div_step;
    logic [XLEN-1:0]   quo, rem;
    assign op_ok = 1'b1;
`else
    assign op_ok = ~op_i[2];
`endif

    assign start = (state_q == MD_IDLE) & valid_i & muldiv_i & ~flush_i & op_ok;
    assign stall_o = start | ((state_q == MD_BUSY) & ~flush_i);
    assign done_o  = (state_q == MD_DONE) & ~flush_i;

    always_comb begin
        a_sgn = (op_i == MD_MULH) | (op_i == MD_MULHSU) | (op_i == MD_DIV) | (op_i == MD_REM);
        b_sgn = (op_i == MD_MULH) | (op_i == MD_DIV) | (op_i == MD_REM);
        a_neg = a_sgn & src_a_i[XLEN-1];
        b_neg = b_sgn & src_b_i[XLEN-1];
        a_mag = a_neg ? -src_a_i : src_a_i;
        b_mag = b_neg ? -src_b_i : src_b_i;
    end

    // Both datapaths share acc: {hi, lo} = {partial product, multiplier} or {remainder, quotient}.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_step = {mul_sum, acc_q[XLEN-1:1]};
`ifdef DIV_EN
        rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge   = rem_sh >= {1'b0, opnd_q};
        div_step = {div_ge ? rem_sh[XLEN-1:0] - opnd_q : rem_sh[XLEN-1:0],
                    acc_q[XLEN-2:0], div_ge};
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        op_d    = op_q;
        neg_d   = neg_q;
`ifdef DIV_EN
        negr_d  = negr_q;
        bzero_d = bzero_q;
`endif
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d = MD_BUSY;
                    cnt_d   = '0;
                    acc_d   = {{XLEN{1'b0}}, a_mag};
                    opnd_d  = b_mag;
                    op_d    = op_i;
                    neg_d   = a_neg ^ b_neg;
`ifdef DIV_EN
                    negr_d  = a_neg;
                    bzero_d = (src_b_i == '0);
`endif
                end
            end
            MD_BUSY: begin
                if (flush_i) begin
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = mul_step;
`ifdef DIV_EN
                    if (op_q[2]) acc_d = div_step;
`endif
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_d = MD_DONE;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_comb begin
        prod     = neg_q ? -acc_q : acc_q;
        result_o = (op_q == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef DIV_EN
        quo = bzero_q ? '1 : (neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
        rem = negr_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        if (op_q[2]) result_o = op_q[1] ? rem : quo;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
`ifdef DIV_EN
            negr_q  <= 1'b0;
            bzero_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
`ifdef DIV_EN
            negr_q  <= negr_d;
            bzero_q <= bzero_d;
`endif
        end
    end

endmodule

// File: rtl/execute_muldiv.sv
// execute_muldiv: RV64I EX stage (forwarding, ALU with Zba, branch/jump resolution) plus muldiv_iter.
// Define DIV_EN to build the divider; without it divide ops return 0 and never stall.
module execute_muldiv
    import exec_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Valid_E,
    input  logic            Flush_E,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] ImmExt_E,
    input  logic [XLEN-1:0] PC_E,
    input  logic [XLEN-1:0] ALUResult_M,
    input  logic [XLEN-1:0] Result_W,
    input  logic [1:0]      ForwardA_E,
    input  logic [1:0]      ForwardB_E,
    input  logic [3:0]      ALUControl_E,
    input  logic            ALUSrc_E,
    input  logic            Branch_E,
    input  logic [2:0]      BranchType_E,
    input  logic            Jump_E,
    input  logic            JumpReg_E,
    input  logic            MulDiv_E,
    input  logic [2:0]      MulDivOp_E,
    output logic [XLEN-1:0] ALUResult_E,
    output logic [XLEN-1:0] WriteData_E,
    output logic [XLEN-1:0] PCTarget_E,
    output logic            PCSrc_E,
    output logic            Stall_E
);

    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] src_a, fwd_b, src_b, alu_out, a_uw, jalr_sum, md_result;
    logic [SHW-1:0]  shamt;
    logic            taken, md_done;

    always_comb begin
        case (ForwardA_E)
            FWD_WB:  src_a = Result_W;
            FWD_MEM: src_a = ALUResult_M;
            default: src_a = RD1_E;
        endcase
        case (ForwardB_E)
            FWD_WB:  fwd_b = Result_W;
            FWD_MEM: fwd_b = ALUResult_M;
            default: fwd_b = RD2_E;
        endcase
        src_b = ALUSrc_E ? ImmExt_E : fwd_b;
    end

    always_comb begin
        shamt = src_b[SHW-1:0];
        a_uw  = XLEN'(64'(src_a[31:0]));
        case (ALUControl_E)
            ALU_ADD:     alu_out = src_a + src_b;
            ALU_SUB:     alu_out = src_a - src_b;
            ALU_AND:     alu_out = src_a & src_b;
            ALU_OR:      alu_out = src_a | src_b;
            ALU_XOR:     alu_out = src_a ^ src_b;
            ALU_SLT:     alu_out = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLTU:    alu_out = {{(XLEN-1){1'b0}}, src_a < src_b};
            ALU_SLL:     alu_out = src_a << shamt;
            ALU_SRL:     alu_out = src_a >> shamt;
            ALU_SRA:     alu_out = $signed(src_a) >>> shamt;
            ALU_SH1ADD:  alu_out = (src_a << 1) + src_b;
            ALU_SH2ADD:  alu_out = (src_a << 2) + src_b;
            ALU_SH3ADD:  alu_out = (src_a << 3) + src_b;
            ALU_ADD_UW:  alu_out = a_uw + src_b;
            ALU_SLLI_UW: alu_out = a_uw << shamt;
            default:     alu_out = '0;
        endcase
    end

    always_comb begin
        case (BranchType_E)
            F3_BEQ:  taken = (src_a == fwd_b);
            F3_BNE:  taken = (src_a != fwd_b);
            F3_BLT:  taken = ($signed(src_a) <  $signed(fwd_b));
            F3_BGE:  taken = ($signed(src_a) >= $signed(fwd_b));
            F3_BLTU: taken = (src_a <  fwd_b);
            F3_BGEU: taken = (src_a >= fwd_b);
            default: taken = 1'b0;
        endcase
        jalr_sum = src_a + ImmExt_E;
    end

    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (Valid_E),
        .flush_i  (Flush_E),
        .muldiv_i (MulDiv_E),
        .op_i     (MulDivOp_E),
        .src_a_i  (src_a),
        .src_b_i  (fwd_b),
        .stall_o  (Stall_E),
        .done_o   (md_done),
        .result_o (md_result)
    );

    assign WriteData_E = fwd_b;
    assign PCTarget_E  = JumpReg_E ? {jalr_sum[XLEN-1:1], 1'b0} : PC_E + ImmExt_E;
    assign PCSrc_E     = Valid_E & ~Flush_E & ~Stall_E & (Jump_E | (Branch_E & taken));
    // M-extension instructions drive 0 until their DONE cycle, covering divides when DIV_EN is absent.
    assign ALUResult_E = md_done ? md_result : (MulDiv_E ? '0 : alu_out);

endmodule

// File: tb/tb_execute_muldiv.sv
// tb_execute_muldiv: table-driven and randomized checks of execute_muldiv against a behavioural model.
// Divide expectations follow the DIV_EN build option.
module tb_execute_muldiv;
    import exec_pkg::*;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        Valid_E, Flush_E, ALUSrc_E, Branch_E, Jump_E, JumpReg_E, MulDiv_E;
    logic [63:0] RD1_E, RD2_E, ImmExt_E, PC_E, ALUResult_M, Result_W;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic [3:0]  ALUControl_E;
    logic [2:0]  BranchType_E, MulDivOp_E;
    logic [63:0] ALUResult_E, WriteData_E, PCTarget_E;
    logic        PCSrc_E, Stall_E;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    execute_muldiv #(.XLEN(64)) dut (
        .clk(clk), .rst(rst), .Valid_E(Valid_E), .Flush_E(Flush_E),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .ImmExt_E(ImmExt_E), .PC_E(PC_E),
        .ALUResult_M(ALUResult_M), .Result_W(Result_W),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .ALUControl_E(ALUControl_E), .ALUSrc_E(ALUSrc_E),
        .Branch_E(Branch_E), .BranchType_E(BranchType_E),
        .Jump_E(Jump_E), .JumpReg_E(JumpReg_E),
        .MulDiv_E(MulDiv_E), .MulDivOp_E(MulDivOp_E),
        .ALUResult_E(ALUResult_E), .WriteData_E(WriteData_E),
        .PCTarget_E(PCTarget_E), .PCSrc_E(PCSrc_E), .Stall_E(Stall_E)
    );

    typedef struct {
        logic        valid, flush;
        logic [1:0]  fa, fb;
        logic [3:0]  op;
        logic        alusrc, br;
        logic [2:0]  bt;
        logic        jmp, jr;
        logic [63:0] rd1, rd2, imm, pc, alum, resw;
        logic [63:0] e_res, e_wd, e_tgt;
        logic        e_pcsrc;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        Valid_E = 1'b1; Flush_E = 1'b0; ALUSrc_E = 1'b0; Branch_E = 1'b0;
        Jump_E = 1'b0; JumpReg_E = 1'b0; MulDiv_E = 1'b0; MulDivOp_E = 3'b000;
        RD1_E = '0; RD2_E = '0; ImmExt_E = '0; PC_E = '0; ALUResult_M = '0; Result_W = '0;
        ForwardA_E = 2'b00; ForwardB_E = 2'b00; ALUControl_E = ALU_ADD; BranchType_E = 3'b000;
    endtask

    function automatic logic [63:0] alu_ref(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] az;
        az = {32'b0, a[31:0]};
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'd6:  return (a < b) ? 64'd1 : 64'd0;
            4'd7:  return a << b[5:0];
            4'd8:  return a >> b[5:0];
            4'd9:  return $signed(a) >>> b[5:0];
            4'd10: return a * 2 + b;
            4'd11: return a * 4 + b;
            4'd12: return a * 8 + b;
            4'd13: return az + b;
            4'd14: return az << b[5:0];
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic branch_ref(input logic [2:0] bt, input logic [63:0] a, input logic [63:0] b);
        case (bt)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return $signed(a) < $signed(b);
            3'b101: return $signed(a) >= $signed(b);
            3'b110: return a < b;
            3'b111: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] md_ref(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic signed [63:0] sa, sb, r;
        sa = a; sb = b;
        case (op)
            3'b000: begin p = {64'b0, a} * {64'b0, b}; return p[63:0]; end
            3'b001: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            3'b010: begin p = {{64{a[63]}}, a} * {64'b0, b}; return p[127:64]; end
            3'b011: begin p = {64'b0, a} * {64'b0, b}; return p[127:64]; end
            3'b100: begin
                if (b == 0) return '1;
                if (a == MIN64 && b == '1) return MIN64;
                r = sa / sb; return r;
            end
            3'b101: return (b == 0) ? '1 : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == MIN64 && b == '1) return 64'd0;
                r = sa % sb; return r;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [63:0] pick_opnd();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'd1;
            2: return '1;
            3: return MIN64;
            4: return {{48{1'b0}}, 16'($urandom)} - 64'd32768;
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    // Holds an M instruction in EX until Stall_E drops, then checks latency and result.
    task automatic run_md(input string name, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        int cycles;
        logic [63:0] exp;
        exp = md_ref(op, a, b);
        idle_inputs();
        MulDiv_E = 1'b1; MulDivOp_E = op; RD1_E = a; RD2_E = b;
        #1;
`ifndef DIV_EN
        if (op[2]) begin
            chk({name, "_nodiv_stall"}, Stall_E, 1'b0);
            chk({name, "_nodiv_res"}, ALUResult_E, 64'd0);
            @(negedge clk); #1;
            chk({name, "_nodiv_nostart"}, Stall_E, 1'b0);
            idle_inputs();
            return;
        end
`endif
        cycles = 0;
        while (Stall_E === 1'b1 && cycles < 300) begin
            cycles++;
            @(negedge clk); #1;
        end
        chk({name, "_lat"}, cycles, 65);
        chk(name, ALUResult_E, exp);
        @(negedge clk);
        idle_inputs();
        #1;
        chk({name, "_after_stall"}, Stall_E, 1'b0);
    endtask

    vec_t vt[$];

    initial begin
        #900000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vt.push_back('{1,0,2'b10,2'b00,ALU_ADD,0,0,3'b000,0,0, 64'd0,64'd7,64'd0,64'h1000,64'd5,64'd0, 64'd12,64'd7,64'h1000,0});
        vt.push_back('{1,0,2'b00,2'b00,ALU_ADD,0,1,3'b110,0,0, 64'd1,'1,64'h10,64'h2000,64'd0,64'd0, 64'd0,'1,64'h2010,1});
        vt.push_back('{1,0,2'b00,2'b00,ALU_ADD,0,1,3'b100,0,0, 64'd1,'1,64'h10,64'h2000,64'd0,64'd0, 64'd0,'1,64'h2010,0});
        vt.push_back('{1,0,2'b00,2'b00,ALU_ADD,1,0,3'b000,1,1, 64'h101,64'd0,64'd4,64'h3000,64'd0,64'd0, 64'h105,64'd0,64'h104,1});
        vt.push_back('{1,0,2'b00,2'b01,ALU_SUB,0,0,3'b000,0,0, 64'd10,64'd99,64'd8,64'h4000,64'd0,64'd3, 64'd7,64'd3,64'h4008,0});
        vt.push_back('{0,0,2'b00,2'b00,ALU_ADD,0,1,3'b000,0,0, 64'd5,64'd5,64'h20,64'h5000,64'd0,64'd0, 64'd10,64'd5,64'h5020,0});
        vt.push_back('{1,1,2'b00,2'b00,ALU_ADD,1,0,3'b000,1,0, 64'd0,64'd0,64'h40,64'h6000,64'd0,64'd0, 64'h40,64'd0,64'h6040,0});
        vt.push_back('{1,0,2'b00,2'b00,ALU_ADD,0,1,3'b101,0,0, 64'hFFFF_FFFF_FFFF_FFFB,64'd3,64'd8,64'h7000,64'd0,64'd0, 64'hFFFF_FFFF_FFFF_FFFE,64'd3,64'h7008,0});
        vt.push_back('{1,0,2'b00,2'b00,ALU_ADD,0,1,3'b111,0,0, 64'hFFFF_FFFF_FFFF_FFFB,64'd3,64'd8,64'h7000,64'd0,64'd0, 64'hFFFF_FFFF_FFFF_FFFE,64'd3,64'h7008,1});
        vt.push_back('{1,0,2'b00,2'b00,ALU_ADD,0,1,3'b010,0,0, 64'd4,64'd4,64'd0,64'h8000,64'd0,64'd0, 64'd8,64'd4,64'h8000,0});
        vt.push_back('{1,0,2'b00,2'b00,ALU_SRA,1,0,3'b000,0,0, MIN64,64'd0,64'd4,64'h9000,64'd0,64'd0, 64'hF800_0000_0000_0000,64'd0,64'h9004,0});
        vt.push_back('{1,0,2'b00,2'b00,ALU_SH3ADD,0,0,3'b000,0,0, 64'd2,64'd5,64'd0,64'hA000,64'd0,64'd0, 64'd21,64'd5,64'hA000,0});
        vt.push_back('{1,0,2'b11,2'b00,ALU_ADD,0,0,3'b000,0,0, 64'd9,64'd1,64'd0,64'hB000,64'd100,64'd200, 64'd10,64'd1,64'hB000,0});
        vt.push_back('{1,0,2'b01,2'b10,ALU_ADD,0,1,3'b001,0,0, 64'd0,64'd1,64'h30,64'hC000,64'd5,64'd5, 64'd10,64'd5,64'hC030,0});

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("reset_stall", Stall_E, 1'b0);
        chk("reset_result", ALUResult_E, 64'd0);
        chk("reset_pcsrc", PCSrc_E, 1'b0);

        foreach (vt[i]) begin
            Valid_E = vt[i].valid; Flush_E = vt[i].flush;
            ForwardA_E = vt[i].fa; ForwardB_E = vt[i].fb; ALUControl_E = vt[i].op;
            ALUSrc_E = vt[i].alusrc; Branch_E = vt[i].br; BranchType_E = vt[i].bt;
            Jump_E = vt[i].jmp; JumpReg_E = vt[i].jr;
            RD1_E = vt[i].rd1; RD2_E = vt[i].rd2; ImmExt_E = vt[i].imm; PC_E = vt[i].pc;
            ALUResult_M = vt[i].alum; Result_W = vt[i].resw;
            #2;
            chk($sformatf("vec%0d_res", i), ALUResult_E, vt[i].e_res);
            chk($sformatf("vec%0d_wd", i), WriteData_E, vt[i].e_wd);
            chk($sformatf("vec%0d_tgt", i), PCTarget_E, vt[i].e_tgt);
            chk($sformatf("vec%0d_pcsrc", i), PCSrc_E, vt[i].e_pcsrc);
            chk($sformatf("vec%0d_stall", i), Stall_E, 1'b0);
        end

        idle_inputs();
        for (int i = 0; i < 200; i++) begin
            ALUControl_E = 4'($urandom_range(0, 15));
            RD1_E = {32'($urandom), 32'($urandom)};
            RD2_E = {32'($urandom), 32'($urandom)};
            #2;
            chk($sformatf("alu_rand%0d_op%0d", i, ALUControl_E), ALUResult_E, alu_ref(ALUControl_E, RD1_E, RD2_E));
        end

        idle_inputs();
        Branch_E = 1'b1;
        for (int i = 0; i < 100; i++) begin
            BranchType_E = 3'($urandom_range(0, 7));
            JumpReg_E = 1'($urandom);
            RD1_E = pick_opnd();
            RD2_E = ($urandom_range(0, 3) == 0) ? RD1_E : pick_opnd();
            ImmExt_E = {32'($urandom), 32'($urandom)};
            PC_E = {32'($urandom), 32'($urandom)};
            #2;
            chk($sformatf("br_rand%0d_pcsrc", i), PCSrc_E, branch_ref(BranchType_E, RD1_E, RD2_E));
            chk($sformatf("br_rand%0d_tgt", i), PCTarget_E,
                JumpReg_E ? ((RD1_E + ImmExt_E) & ~64'd1) : PC_E + ImmExt_E);
        end

        idle_inputs();
        @(negedge clk);
        run_md("mulh_m3x5", MD_MULH, -64'sd3, 64'd5);
        run_md("mul_3x4", MD_MUL, 64'd3, 64'd4);
        run_md("div_7by0", MD_DIV, 64'd7, 64'd0);
        run_md("rem_7by0", MD_REM, 64'd7, 64'd0);
        run_md("divu_7by0", MD_DIVU, 64'd7, 64'd0);
        run_md("div_min_m1", MD_DIV, MIN64, '1);
        run_md("rem_min_m1", MD_REM, MIN64, '1);
        run_md("rem_m7by2", MD_REM, -64'sd7, 64'd2);

        for (int i = 0; i < 40; i++)
            run_md($sformatf("md_rand%0d", i), 3'($urandom_range(0, 7)), pick_opnd(), pick_opnd());

        idle_inputs();
        MulDiv_E = 1'b1; MulDivOp_E = MD_MULHU; RD1_E = '1; RD2_E = '1;
        #1;
        repeat (11) @(negedge clk);
        #1;
        chk("flush_pre_stall", Stall_E, 1'b1);
        Flush_E = 1'b1;
        #1;
        chk("flush_cycle_stall", Stall_E, 1'b0);
        @(negedge clk);
        idle_inputs();
        RD1_E = 64'd20; RD2_E = 64'd22;
        #1;
        chk("post_flush_stall", Stall_E, 1'b0);
        chk("post_flush_add", ALUResult_E, 64'd42);
        @(negedge clk); #1;
        chk("post_flush_idle", Stall_E, 1'b0);

        idle_inputs();
        MulDiv_E = 1'b1; MulDivOp_E = MD_MUL; RD1_E = 64'd7; RD2_E = 64'd9;
        #1;
        repeat (5) @(negedge clk);
        #1;
        chk("rst_pre_stall", Stall_E, 1'b1);
        rst = 1'b1; MulDiv_E = 1'b0; RD1_E = 64'd1; RD2_E = 64'd2;
        #1;
        chk("rst_comb_add", ALUResult_E, 64'd3);
        @(negedge clk); #1;
        chk("rst_next_stall", Stall_E, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run_md("mul_after_rst", MD_MUL, 64'd3, 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
